// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared types and encodings for the Hamming syndrome stage
package hamming_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        SCAN    = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int CW_BITS   = 16;
    localparam int SYN_BITS  = 4;
    localparam int BYTE_BITS = 8;

    // Encodings the downstream LUT mux register expects
    localparam logic [7:0] PAR_OK  = 8'd0;
    localparam logic [7:0] PAR_ERR = 8'd1;

endpackage

// File: rtl/hamming_syndrome_gen.sv
// rtl/hamming_syndrome_gen.sv - two-byte codeword capture, serial syndrome/parity scan, held result
module hamming_syndrome_gen
    import hamming_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [BYTE_BITS-1:0] InByte,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic                 OutReady,
    output logic                 OutValid,
    output logic [W-1:0]         Syndrome,
    output logic [W-1:0]         ParityErr,
    output logic [CW_BITS-1:0]   Codeword,
    output logic                 Busy
);

    state_t              state;
    state_t              nextState;
    logic [SYN_BITS-1:0] k;
    logic [SYN_BITS-1:0] synAcc;
    logic                parAcc;
    logic                nextInReady;
    logic                accept;
    logic                release_;

    assign accept   = InValid && InReady;
    assign release_ = OutValid && OutReady;
    assign Busy     = (state != IDLE);

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = WAIT_HI;
            WAIT_HI: if (accept) nextState = SCAN;
            SCAN:    if (k == 4'd15) nextState = DONE;
            DONE:    if (release_) nextState = IDLE;
            default: nextState = IDLE;
        endcase
        // Registered so that the first cycle after reset still reports not-ready
        nextInReady = (nextState == IDLE) || (nextState == WAIT_HI);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            k         <= '0;
            synAcc    <= '0;
            parAcc    <= 1'b0;
            InReady   <= 1'b0;
            OutValid  <= 1'b0;
            Syndrome  <= '0;
            ParityErr <= '0;
            Codeword  <= '0;
        end else begin
            state   <= nextState;
            InReady <= nextInReady;
            case (state)
                IDLE: begin
                    if (accept) Codeword[7:0] <= InByte;
                end
                WAIT_HI: begin
                    if (accept) begin
                        Codeword[15:8] <= InByte;
                        k              <= '0;
                        synAcc         <= '0;
                        parAcc         <= 1'b0;
                    end
                end
                SCAN: begin
                    parAcc <= parAcc ^ Codeword[k];
                    if (Codeword[k] && (k != 4'd0)) synAcc <= synAcc ^ k;
                    if (k != 4'd15) k <= k + 4'd1;
                end
                DONE: begin
                    // First DONE cycle publishes the accumulators; later cycles just hold
                    if (!OutValid) begin
                        OutValid  <= 1'b1;
                        Syndrome  <= W'(synAcc);
                        ParityErr <= parAcc ? W'(PAR_ERR) : W'(PAR_OK);
                    end else if (OutReady) begin
                        OutValid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_syndrome_gen.sv
// tb/tb_hamming_syndrome_gen.sv - self-checking bench for hamming_syndrome_gen
module tb_hamming_syndrome_gen;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [7:0]  InByte = 8'h00;
    logic        InValid = 1'b0;
    logic        OutReady = 1'b0;
    logic        InReady;
    logic        OutValid;
    logic [7:0]  Syndrome;
    logic [7:0]  ParityErr;
    logic [15:0] Codeword;
    logic        Busy;

    int vectors = 0;
    int miscompares = 0;

    hamming_syndrome_gen #(.W(8)) dut (
        .Clk(Clk), .Reset(Reset), .InByte(InByte), .InValid(InValid), .InReady(InReady),
        .OutReady(OutReady), .OutValid(OutValid), .Syndrome(Syndrome), .ParityErr(ParityErr),
        .Codeword(Codeword), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    function automatic logic [3:0] refSyn(input logic [15:0] cw);
        logic [3:0] s = 4'd0;
        for (int i = 1; i < 16; i++) if (cw[i]) s = s ^ 4'(i);
        return s;
    endfunction

    function automatic logic refPar(input logic [15:0] cw);
        return ($countones(cw) % 2) == 1;
    endfunction

    // Transaction-level model: readiness, busy, and when/what the result must be
    int          cyc = 0;
    int          validAt = -1;
    logic        mRdy = 1'b0;
    logic        mHaveLo = 1'b0;
    logic        mBusy = 1'b0;
    logic        mScan = 1'b0;
    logic        mOutValid = 1'b0;
    logic [7:0]  mLo = 8'h00;
    logic [15:0] mCw = 16'h0000;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cyc <= 0; validAt <= -1; mRdy <= 1'b0; mHaveLo <= 1'b0;
            mBusy <= 1'b0; mScan <= 1'b0; mOutValid <= 1'b0; mLo <= 8'h00; mCw <= 16'h0000;
        end else begin
            cyc <= cyc + 1;
            if (mOutValid && OutReady) begin
                mOutValid <= 1'b0; mBusy <= 1'b0; mRdy <= 1'b1;
            end else if (mScan && (cyc + 1 == validAt)) begin
                mOutValid <= 1'b1; mScan <= 1'b0;
            end else if (mRdy && InValid) begin
                if (!mHaveLo) begin
                    mLo <= InByte; mHaveLo <= 1'b1; mBusy <= 1'b1;
                end else begin
                    mCw <= {InByte, mLo}; mHaveLo <= 1'b0; mRdy <= 1'b0;
                    mScan <= 1'b1; validAt <= cyc + 1 + 17;
                end
            end else if (!mBusy) begin
                mRdy <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        int tries = 0;
        InByte = b;
        InValid = 1'b1;
        while (!InReady && tries < 60) begin
            @(negedge Clk);
            tries++;
        end
        if (!InReady) check("sendTimeout", InReady, 1);
        @(posedge Clk);
        @(negedge Clk);
        InValid = 1'b0;
    endtask

    task automatic waitValid(output int n);
        n = 0;
        while (!OutValid && n < 60) begin
            @(negedge Clk);
            n++;
        end
    endtask

    task automatic consume();
        OutReady = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        OutReady = 1'b0;
    endtask

    task automatic runCw(input logic [7:0] lo, input logic [7:0] hi,
                         input logic [7:0] eSyn, input logic [7:0] ePar);
        int n;
        sendByte(lo);
        sendByte(hi);
        waitValid(n);
        check("latency", n, 17);
        check("litSyndrome", Syndrome, eSyn);
        check("litParityErr", ParityErr, ePar);
        check("litCodeword", Codeword, {hi, lo});
        consume();
    endtask

    task automatic pulseReset();
        #2 Reset = 1'b1;
        #1;
        check("rstSyndrome", Syndrome, 0);
        check("rstParityErr", ParityErr, 0);
        check("rstCodeword", Codeword, 0);
        check("rstOutValid", OutValid, 0);
        check("rstInReady", InReady, 0);
        check("rstBusy", Busy, 0);
        @(negedge Clk);
        Reset = 1'b0;
        #1 check("rdyAfterRst", InReady, 0);
        @(negedge Clk);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge Clk);
        check("rstSyndrome0", Syndrome, 0);
        check("rstOutValid0", OutValid, 0);
        check("rstInReady0", InReady, 0);
        Reset = 1'b0;
        #1 check("rdyFirstCycle", InReady, 0);

        fork
            forever begin
                @(negedge Clk);
                if (!Reset) begin
                    check("InReady", InReady, mRdy);
                    check("OutValid", OutValid, mOutValid);
                    check("Busy", Busy, mBusy);
                    if (mOutValid) begin
                        check("Syndrome", Syndrome, refSyn(mCw));
                        check("ParityErr", ParityErr, refPar(mCw));
                        check("Codeword", Codeword, mCw);
                    end
                end
            end
        join_none

        @(negedge Clk);
        runCw(8'h00, 8'h00, 8'd0, 8'd0);
        runCw(8'h20, 8'h00, 8'd5, 8'd1);
        runCw(8'h28, 8'h00, 8'd6, 8'd0);
        runCw(8'h01, 8'h80, 8'd15, 8'd0);
        runCw(8'h01, 8'h00, 8'd0, 8'd1);

        // Backpressure with a pending 0xFF that must later land as the low byte
        sendByte(8'h28);
        sendByte(8'h00);
        waitValid(n);
        InByte = 8'hFF;
        InValid = 1'b1;
        repeat (5) begin
            @(negedge Clk);
            check("bpInReady", InReady, 0);
            check("bpOutValid", OutValid, 1);
            check("bpSyndrome", Syndrome, 8'd6);
            check("bpCodeword", Codeword, 16'h0028);
        end
        OutReady = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        OutReady = 1'b0;
        check("idleInReady", InReady, 1);
        check("idleOutValid", OutValid, 0);
        @(posedge Clk);
        @(negedge Clk);
        InValid = 1'b0;
        sendByte(8'h00);
        waitValid(n);
        check("ffLowCodeword", Codeword, 16'h00FF);
        check("ffLowSyndrome", Syndrome, 8'd0);
        check("ffLowParity", ParityErr, 8'd0);
        consume();

        // Reset in the middle of SCAN at k=7
        sendByte(8'h55);
        sendByte(8'hAA);
        repeat (7) @(negedge Clk);
        pulseReset();
        runCw(8'h20, 8'h00, 8'd5, 8'd1);

        // Reset while waiting for the high byte discards the partial codeword
        sendByte(8'h77);
        pulseReset();
        runCw(8'h01, 8'h80, 8'd15, 8'd0);

        for (int t = 0; t < 40; t++) begin
            logic [7:0] lo;
            logic [7:0] hi;
            lo = 8'($urandom);
            hi = 8'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge Clk);
            sendByte(lo);
            repeat ($urandom_range(0, 3)) @(negedge Clk);
            sendByte(hi);
            waitValid(n);
            check("rndValid", OutValid, 1);
            repeat ($urandom_range(0, 3)) @(negedge Clk);
            consume();
        end

        repeat (3) @(negedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hamming_syndrome_gen.md
Name: hamming_syndrome_gen

Overview:
Upstream stage of the SECDED error-mapping LUT. Accepts a received 16-bit Hamming codeword as two bytes from the data-memory read path, then scans it serially one bit per cycle. It produces the 4-bit syndrome, which drives the LUT entry register, and the overall-parity-error flag, which drives the LUT mux register. It holds the result plus the raw codeword under a valid/ready handshake until the downstream correction stage consumes it.

Parameters:
W, 8, width of the Syndrome and ParityErr outputs (zero-extended); must be >= 4

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
InByte  input  8  codeword byte; low byte (bits 7:0) first, then high byte (bits 15:8)
InValid  input  1  InByte valid
InReady  output  1  block accepts InByte this cycle
OutReady  input  1  downstream accepts result
OutValid  output  1  Syndrome/ParityErr/Codeword valid
Syndrome  output  W  XOR of positions i (1..15) where codeword bit i = 1; upper W-4 bits are 0
ParityErr  output  W  8'd1 if XOR of all 16 bits = 1, else 8'd0 (zero-extended to W)
Codeword  output  16  received codeword, held with the result
Busy  output  1  high in WAIT_HI, SCAN and DONE

Behaviour:
- One clock (Clk); asynchronous active-high Reset. On Reset: state=IDLE, all outputs and internal registers 0, InReady=0 until the first clock after deassertion.
- States: IDLE -> WAIT_HI -> SCAN -> DONE -> IDLE.
- IDLE: InReady=1. On InValid, latch InByte into Codeword[7:0] and go to WAIT_HI.
- WAIT_HI: InReady=1. On InValid, latch InByte into Codeword[15:8], clear accumulators and bit counter k=0, go to SCAN. Waits indefinitely otherwise.
- SCAN: InReady=0. Each cycle process bit k:
  - par ^= cw[k]
  - if cw[k] and k != 0, syn ^= k[3:0]
  - k++
- SCAN ends after k=15 (exactly 16 cycles), then go to DONE.
- Latency: high byte accepted at edge T; OutValid=1 from edge T+17.
- DONE: OutValid=1. Syndrome, ParityErr and Codeword stay stable while OutReady=0. On OutReady, go to IDLE; OutValid drops the next cycle; InReady=1 in that IDLE cycle.
- InReady=0 in SCAN and DONE. InValid is ignored there; no data is lost, because the upstream holds InByte under the handshake.
- Counter: 4-bit k; k=15 terminates the scan with no wrap past it. Syndrome is 4 bits, so its arithmetic is pure XOR with no overflow.
- Reset mid-operation (any state): immediate return to IDLE and outputs to 0. A partial codeword is discarded; the next byte accepted is treated as a low byte.
- Results are consistent with the downstream LUT:
  - ParityErr=0, Syndrome=0: no error.
  - ParityErr=0, Syndrome!=0: double error.
  - ParityErr=1: single-bit or parity-bit error.
- Outputs are registered; no combinational path from inputs to OutValid/InReady.

Decomposition:
- Shared package hamming_pkg holds:
  - enum state_t {IDLE, WAIT_HI, SCAN, DONE}
  - constants CW_BITS=16, SYN_BITS=4, BYTE_BITS=8
  - LUT-facing encodings PAR_OK=8'd0, PAR_ERR=8'd1
- No sub-module. The accumulator, counter and FSM together form a single always_ff plus a small always_comb for next-state and InReady.

Test Plan:
- Bytes 0x00, 0x00 -> OutValid at T+17; Syndrome=0, ParityErr=0, Codeword=0x0000.
- Bytes 0x20, 0x00 (bit 5 set) -> Syndrome=5, ParityErr=1.
- Bytes 0x28, 0x00 (bits 3 and 5) -> Syndrome=6, ParityErr=0 (double error).
- Bytes 0x01, 0x80 (bits 0 and 15) -> Syndrome=15, ParityErr=0.
- Bytes 0x01, 0x00 -> Syndrome=0, ParityErr=1.
- Backpressure: OutReady=0 for 5 cycles in DONE, with InValid=1 and byte 0xFF throughout -> outputs stable and InReady=0. Raise OutReady -> IDLE, then 0xFF accepted as a low byte.
- Reset at SCAN k=7 -> all outputs 0 immediately. Then bytes 0x20, 0x00 -> Syndrome=5, ParityErr=1 with T+17 latency.
